ahb2apb_bridge: RTL and testbench
=================================

Name: ahb2apb_bridge

Overview:
- AHB-Lite slave to APB master bridge, single APB slave, 32-bit data.
- Sits directly upstream of the team's APB peripherals (timer, etc.) and drives their paddr/psel/penable/pwrite/pwdata; consumes prdata/pready/pslverr.
- Each AHB transfer becomes exactly one APB SETUP+ACCESS transfer. hreadyout is held low until the APB transfer completes.
- Adds a wait-state timeout so a hung slave cannot lock the bus.

Parameters:
- paddr_w, 5, APB address width; paddr = haddr[paddr_w-1:0].
- tmo_w, 8, timeout counter width; an access aborts after 2^tmo_w-1 ACCESS cycles without pready.

Ports:
- clk  in  1  single clock for both AHB and APB sides.
- rst  in  1  reset, asynchronous, active-high.
- hsel  in  1  AHB slave select.
- haddr  in  32  AHB address.
- htrans  in  2  AHB transfer type; only bit 1 is used (NONSEQ/SEQ = transfer).
- hwrite  in  1  AHB write.
- hwdata  in  32  AHB write data, valid in the data phase.
- hready  in  1  AHB bus ready (previous data phase done).
- hrdata  out  32  AHB read data, registered.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- paddr  out  paddr_w  APB address.
- pwdata  out  32  APB write data.
- pwrite  out  1  APB write.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- prdata  in  32  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

Behaviour:
- Reset (async, any state, immediate): state=IDLE; hreadyout=1, hresp=0, hrdata=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, timeout counter=0. An in-flight APB access is abandoned and no response is given.
- All outputs are registered, driven from the FSM and data registers.
- FSM states: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- IDLE:
  - Accept when hsel & htrans[1] & hready. On accept: capture paddr<=haddr[paddr_w-1:0], pwrite<=hwrite, hreadyout<=0.
  - Next state is WDATA if write, SETUP if read.
  - If not accepted (including htrans IDLE/BUSY): stay, hreadyout=1, hresp=0 (zero-wait OKAY).
  - Transfers are accepted only in IDLE; back-to-back transfers are stalled by hreadyout=0.
- WDATA (writes only, 1 cycle): pwdata<=hwdata; go SETUP.
- SETUP (1 cycle): psel=1, penable=0; go ACCESS. Timeout counter cleared.
- ACCESS: psel=1, penable=1. Exits, checked in priority order:
  1. pready & pslverr: go ERR1.
  2. pready & !pslverr: hrdata<=prdata on reads only (unchanged on writes); hreadyout<=1, psel<=0, penable<=0; go IDLE.
  3. !pready & counter==2^tmo_w-1: psel<=0, penable<=0; go ERR1 (timeout).
  4. Otherwise: counter+1, stay.
- ERR1: psel=0, penable=0, hresp=1, hreadyout=0; go ERR2.
- ERR2: hresp=1, hreadyout=1; go IDLE, where hresp returns to 0. This is the standard two-cycle AHB ERROR response.
- Latency from the address-phase accept edge to hreadyout=1 with zero APB wait states: read 3 cycles, write 4 cycles. Each APB wait state adds 1 cycle.
- Inputs sampled only as stated:
  - paddr/pwrite are stable from SETUP through ACCESS.
  - prdata is sampled only on a pready cycle.
  - hwdata is sampled only in WDATA.
- haddr bits above paddr_w are ignored; hsize and hprot are not ports; no pstrb, so writes are always 32-bit.
- pready/pslverr are ignored outside ACCESS.

Test Plan:
- Read, pready tied to penable, prdata=0xDEADBEEF, haddr=0x14: paddr=0x14; psel high 2 cycles, penable high in the 2nd; hreadyout=1 with hrdata=0xDEADBEEF 3 cycles after accept; hresp=0.
- Write haddr=0x08, hwdata=0x000000A5 in data phase: pwdata=0xA5, pwrite=1 from SETUP; single ACCESS cycle; hreadyout=1 4 cycles after accept; hresp=0.
- Read with pready held low 3 ACCESS cycles: ACCESS lasts 4 cycles; completion 6 cycles after accept; paddr/psel stable throughout.
- Write with pready=1 & pslverr=1 in ACCESS: hresp=1/hreadyout=0 one cycle, then hresp=1/hreadyout=1, then IDLE with hresp=0.
- pready never asserted, tmo_w=4: psel drops after 15 ACCESS cycles; two-cycle ERROR follows; the next transfer then completes normally.
- Assert rst while in ACCESS: psel/penable/hresp drop to 0 and hreadyout=1 immediately, without waiting for a clock edge. htrans=IDLE with hsel=1 after release: no APB activity, hreadyout stays 1.

Source files
------------

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge for a single APB slave, 32-bit data.
// One AHB transfer becomes one APB SETUP+ACCESS; a wait-state timeout aborts hung accesses with ERROR.
module ahb2apb_bridge #(
  parameter int paddr_w = 5,
  parameter int tmo_w   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hsel,
  input  logic [31:0]        haddr,
  input  logic [1:0]         htrans,
  input  logic               hwrite,
  input  logic [31:0]        hwdata,
  input  logic               hready,
  output logic [31:0]        hrdata,
  output logic               hreadyout,
  output logic               hresp,
  output logic [paddr_w-1:0] paddr,
  output logic [31:0]        pwdata,
  output logic               pwrite,
  output logic               psel,
  output logic               penable,
  input  logic [31:0]        prdata,
  input  logic               pready,
  input  logic               pslverr
);

  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_t;

  localparam logic [tmo_w-1:0] tmo_max = '1;

  state_t             state_q, state_d;
  logic [31:0]        hrdata_q, hrdata_d;
  logic               hreadyout_q, hreadyout_d;
  logic               hresp_q, hresp_d;
  logic [paddr_w-1:0] paddr_q, paddr_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic               pwrite_q, pwrite_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic [tmo_w-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic unused_inputs;
  assign unused_inputs = ^{haddr[31:paddr_w], htrans[0]};

  always_comb begin
    state_d     = state_q;
    hrdata_d    = hrdata_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    tmo_cnt_d   = tmo_cnt_q;
    case (state_q)
      IDLE: begin
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        if (hsel && htrans[1] && hready) begin
          paddr_d     = haddr[paddr_w-1:0];
          pwrite_d    = hwrite;
          hreadyout_d = 1'b0;
          if (hwrite) begin
            state_d = WDATA;
          end else begin
            state_d = SETUP;
            psel_d  = 1'b1;
          end
        end
      end
      WDATA: begin
        pwdata_d = hwdata;
        psel_d   = 1'b1;
        state_d  = SETUP;
      end
      SETUP: begin
        penable_d = 1'b1;
        // Counter holds the number of the current ACCESS cycle, so the abort
        // comes after exactly tmo_max cycles without pready.
        tmo_cnt_d = tmo_w'(1);
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready && pslverr) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          hresp_d   = 1'b1;
          state_d   = ERR1;
        end else if (pready) begin
          if (!pwrite_q) hrdata_d = prdata;
          hreadyout_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end else if (tmo_cnt_q == tmo_max) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          hresp_d   = 1'b1;
          state_d   = ERR1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + tmo_w'(1);
        end
      end
      ERR1: begin
        hresp_d     = 1'b1;
        hreadyout_d = 1'b1;
        state_d     = ERR2;
      end
      ERR2: begin
        hresp_d     = 1'b0;
        hreadyout_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d     = IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hrdata_q    <= hrdata_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign hrdata    = hrdata_q;
  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwrite    = pwrite_q;
  assign psel      = psel_q;
  assign penable   = penable_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Bench for ahb2apb_bridge: table of AHB transfers against a small APB slave model,
// with a scoreboard of expected responses plus hand-written reset/no-accept sequences.
module tb_ahb2apb_bridge;

  localparam int PADDR_W = 5;
  localparam int TMO_W   = 4;
  localparam int BUDGET  = 60;

  logic               clk;
  logic               rst;
  logic               hsel;
  logic [31:0]        haddr;
  logic [1:0]         htrans;
  logic               hwrite;
  logic [31:0]        hwdata;
  logic               hready;
  logic [31:0]        hrdata;
  logic               hreadyout;
  logic               hresp;
  logic [PADDR_W-1:0] paddr;
  logic [31:0]        pwdata;
  logic               pwrite;
  logic               psel;
  logic               penable;
  logic [31:0]        prdata;
  logic               pready;
  logic               pslverr;

  ahb2apb_bridge #(.paddr_w(PADDR_W), .tmo_w(TMO_W)) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hwdata(hwdata), .hready(hready), .hrdata(hrdata),
    .hreadyout(hreadyout), .hresp(hresp), .paddr(paddr), .pwdata(pwdata),
    .pwrite(pwrite), .psel(psel), .penable(penable), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // APB slave model: pready after apb_waits wait states, never if apb_hang.
  int          apb_waits;
  logic        apb_err;
  logic        apb_hang;
  logic [31:0] apb_rdata;
  int          acc_cnt;

  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
  end

  assign pready  = psel && penable && !apb_hang && (acc_cnt >= apb_waits);
  assign pslverr = apb_err && pready;
  assign prdata  = apb_rdata;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        err;
    logic        hang;
    logic [4:0]  exp_paddr;
    int          exp_lat;
    logic        exp_hresp;
  } vec_t;

  typedef struct {
    logic [31:0] hrdata;
    logic        hresp;
    int          lat;
    logic [4:0]  paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    int          psel_cycles;
  } exp_t;

  vec_t        vecs[9];
  exp_t        sb_q[$];
  int          checks;
  int          errors;
  logic [31:0] hrdata_model;
  logic [31:0] pwdata_model;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_xfer(input vec_t v, input int idx);
    exp_t        e;
    int          lat;
    int          psel_c;
    int          pen_c;
    logic [4:0]  setup_paddr;
    logic        setup_pwrite;
    logic [31:0] setup_pwdata;
    logic        stable;
    logic        pre_hresp;
    logic        done;
    lat = 0; psel_c = 0; pen_c = 0; stable = 1'b1; pre_hresp = 1'b0; done = 1'b0;
    setup_paddr = '0; setup_pwrite = 1'b0; setup_pwdata = '0;

    if (!v.wr && !v.err && !v.hang) hrdata_model = v.rdata;
    if (v.wr) pwdata_model = v.wdata;
    e.hrdata      = hrdata_model;
    e.hresp       = v.exp_hresp;
    e.lat         = v.exp_lat;
    e.paddr       = v.exp_paddr;
    e.pwrite      = v.wr;
    e.pwdata      = pwdata_model;
    e.psel_cycles = v.hang ? (1 << TMO_W) : v.waits + 2;
    sb_q.push_back(e);

    apb_waits = v.waits; apb_err = v.err; apb_hang = v.hang; apb_rdata = v.rdata;
    hsel = 1'b1; htrans = 2'b10; haddr = v.addr; hwrite = v.wr; hready = 1'b1;
    hwdata = 32'hBAD0_BAD0;
    @(negedge clk);
    lat = 1;
    hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwdata = v.wdata;
    while (1) begin
      if (psel) begin
        psel_c++;
        if (!penable) begin
          setup_paddr = paddr; setup_pwrite = pwrite; setup_pwdata = pwdata;
        end else if (paddr !== setup_paddr || pwrite !== setup_pwrite) begin
          stable = 1'b0;
        end
        if (penable) pen_c++;
      end
      if (hreadyout) begin
        done = 1'b1;
        break;
      end
      pre_hresp = hresp;
      if (lat >= BUDGET) break;
      @(negedge clk);
      lat++;
      hwdata = 32'hBAD0_BAD0;
    end

    e = sb_q.pop_front();
    chk("complete", 32'(done), 32'd1);
    chk("latency", 32'(lat), 32'(e.lat));
    chk("hresp", 32'(hresp), 32'(e.hresp));
    chk("hresp_before_ready", 32'(pre_hresp), 32'(e.hresp));
    chk("hrdata", hrdata, e.hrdata);
    chk("paddr", 32'(setup_paddr), 32'(e.paddr));
    chk("pwrite", 32'(setup_pwrite), 32'(e.pwrite));
    chk("pwdata", setup_pwdata, e.pwdata);
    chk("psel_cycles", 32'(psel_c), 32'(e.psel_cycles));
    chk("penable_cycles", 32'(pen_c), 32'(e.psel_cycles - 1));
    chk("paddr_stable", 32'(stable), 32'd1);
    $display("xfer %0d: %s addr=0x%08h lat=%0d hresp=%0d hrdata=0x%08h psel_cycles=%0d",
             idx, v.wr ? "WR" : "RD", v.addr, lat, hresp, hrdata, psel_c);
    @(negedge clk);
    chk("idle_hresp", 32'(hresp), 32'd0);
    chk("idle_hreadyout", 32'(hreadyout), 32'd1);
    chk("idle_psel", 32'(psel), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    hrdata_model = '0; pwdata_model = '0;
    rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hwdata = '0; hready = 1'b1;
    apb_waits = 0; apb_err = 1'b0; apb_hang = 1'b0; apb_rdata = '0;

    //          wr    addr          wdata         rdata         wt err   hang  paddr  lat hresp
    vecs[0] = '{1'b0, 32'h0000_0014, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 1'b0, 5'h14, 3,  1'b0};
    vecs[1] = '{1'b1, 32'h0000_0008, 32'h0000_00A5, 32'h1111_1111, 0, 1'b0, 1'b0, 5'h08, 4,  1'b0};
    vecs[2] = '{1'b0, 32'h0000_000C, 32'h0,        32'h1234_5678, 3, 1'b0, 1'b0, 5'h0C, 6,  1'b0};
    vecs[3] = '{1'b1, 32'h0000_0010, 32'h5555_AAAA, 32'h2222_2222, 0, 1'b1, 1'b0, 5'h10, 5,  1'b1};
    vecs[4] = '{1'b0, 32'h0000_0004, 32'h0,        32'h3333_3333, 0, 1'b0, 1'b1, 5'h04, 18, 1'b1};
    vecs[5] = '{1'b0, 32'hFFFF_FF1C, 32'h0,        32'hCAFE_F00D, 0, 1'b0, 1'b0, 5'h1C, 3,  1'b0};
    vecs[6] = '{1'b1, 32'h0000_001F, 32'hFFFF_0000, 32'h4444_4444, 2, 1'b0, 1'b0, 5'h1F, 6,  1'b0};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'h0,        32'h6666_6666, 1, 1'b1, 1'b0, 5'h00, 5,  1'b1};
    vecs[8] = '{1'b1, 32'h0000_0003, 32'h7777_8888, 32'h0,        0, 1'b0, 1'b1, 5'h03, 19, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    rst = 1'b0;

    // Selected transfer with hready low, then BUSY: neither may be accepted.
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h14; hready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("noacc_hready_psel", 32'(psel), 32'd0);
      chk("noacc_hready_hreadyout", 32'(hreadyout), 32'd1);
    end
    hready = 1'b1; htrans = 2'b01;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("noacc_busy_psel", 32'(psel), 32'd0);
      chk("noacc_busy_hreadyout", 32'(hreadyout), 32'd1);
    end
    hsel = 1'b0; htrans = 2'b00;
    $display("no-accept sequence done");

    for (int i = 0; i < 9; i++) run_xfer(vecs[i], i);

    // Reset asserted mid-ACCESS must clear outputs before the next clock edge.
    apb_hang = 1'b1; apb_err = 1'b0; apb_waits = 0;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h18; hwrite = 1'b0; hready = 1'b1;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00;
    for (int i = 0; i < 10 && !penable; i++) @(negedge clk);
    chk("reach_access", 32'(penable), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_psel", 32'(psel), 32'd0);
    chk("async_penable", 32'(penable), 32'd0);
    chk("async_hresp", 32'(hresp), 32'd0);
    chk("async_hreadyout", 32'(hreadyout), 32'd1);
    chk("async_hrdata", hrdata, 32'd0);
    hrdata_model = '0; pwdata_model = '0;
    $display("async reset in ACCESS done");
    @(negedge clk);
    rst = 1'b0; apb_hang = 1'b0;
    hsel = 1'b1; htrans = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle_psel", 32'(psel), 32'd0);
      chk("post_rst_idle_hreadyout", 32'(hreadyout), 32'd1);
    end
    hsel = 1'b0;
    run_xfer(vecs[0], 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
